a2d_rr_sampler: RTL

- Round-robin A2D sequencer that sits directly upstream of the 16-bit SPI master.
- Drives the master's wrt/cmd pair and consumes its done/rd_data, running one sweep over the enabled channels of the 8-channel ADC128S.
- The ADC returns a result one transaction late, so each conversion takes two SPI transactions: a channel-select send, then a read.
- Results are held in per-channel registers that downstream control logic reads through a select/data port.

---
 rtl/a2d_pkg.sv | 21 ++
 rtl/a2d_prio_next.sv | 24 ++
 rtl/a2d_rr_sampler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the round-robin A2D sampler.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT1,
        GAP,
        READ,
        WAIT2,
        STORE
    } state_t;

    localparam logic [10:0] ADC_CMD_PAD = 11'h000;

    // ADC128S control word: channel address sits in bits [13:11]
    function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
        return {2'b00, ch, ADC_CMD_PAD};
    endfunction

endpackage

// File: rtl/a2d_prio_next.sv
// Finds the next enabled channel: lowest set mask bit above cur, or from bit 0 when from_start.
module a2d_prio_next #(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [2:0]        cur,
    input  logic              from_start,
    output logic [2:0]        nxt,
    output logic              last
);

    // Scan downwards so the lowest qualifying bit wins
    always_comb begin
        nxt  = '0;
        last = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                nxt  = 3'(i);
                last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/a2d_rr_sampler.sv
// Round-robin ADC128S sweep sequencer driving a 16-bit SPI master.
// Define A2D_AVG_EN to average each new sample with the stored result.
module a2d_rr_sampler
    import a2d_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int RES_W   = 12,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strt_sweep,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              wrt,
    output logic [15:0]       cmd,
    input  logic              spi_done,
    input  logic [15:0]       rd_data,
    input  logic [2:0]        res_sel,
    output logic [RES_W-1:0]  res_data,
    output logic              busy,
    output logic              sweep_done,
    output logic [NUM_CH-1:0] res_vld
);

    state_t              state, state_nxt;
    logic [NUM_CH-1:0]   mask_q;
    logic [2:0]          ch_q;
    logic [3:0]          gap_cnt;
    logic                done_q;
    logic                done_rise;
    logic [RES_W-1:0]    res [NUM_CH];
    logic [RES_W-1:0]    new_val;
    logic [RES_W-1:0]    store_val;
    logic                rd_unused;

    logic [NUM_CH-1:0]   pn_mask;
    logic                pn_from_start;
    logic [2:0]          pn_nxt;
    logic                pn_last;

    logic                start_go;
    logic                start_empty;
    logic                finish;
    logic                store_en;

    // Only a fresh 0->1 transition counts, so a done level left over from the
    // previous transaction cannot complete the next one early
    assign done_rise = spi_done & ~done_q;
    assign new_val   = rd_data[RES_W-1:0];
    assign rd_unused = ^rd_data[15:RES_W];
    assign busy      = (state != IDLE);
    assign cmd       = mk_cmd(ch_q);

    // Same finder serves sweep start (live mask) and channel advance (latched mask)
    always_comb begin
        pn_from_start = (state == IDLE);
        pn_mask       = (state == IDLE) ? ch_mask : mask_q;
    end

    a2d_prio_next #(.NUM_CH(NUM_CH)) u_prio (
        .mask       (pn_mask),
        .cur        (ch_q),
        .from_start (pn_from_start),
        .nxt        (pn_nxt),
        .last       (pn_last)
    );

`ifdef A2D_AVG_EN
    logic [RES_W:0] avg_sum;
    assign avg_sum   = {1'b0, res[ch_q]} + {1'b0, new_val};
    assign store_val = res_vld[ch_q] ? avg_sum[RES_W:1] : new_val;
`else
    assign store_val = new_val;
`endif

    always_comb begin
        res_data = '0;
        if (int'(res_sel) < NUM_CH)
            res_data = res[res_sel];
    end

    always_comb begin
        state_nxt   = state;
        wrt         = 1'b0;
        start_go    = 1'b0;
        start_empty = 1'b0;
        finish      = 1'b0;
        store_en    = 1'b0;
        case (state)
            IDLE: begin
                if (strt_sweep) begin
                    if (|ch_mask) begin
                        start_go  = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        start_empty = 1'b1;
                    end
                end
            end
            SEND: begin
                wrt       = 1'b1;
                state_nxt = WAIT1;
            end
            WAIT1: if (done_rise) state_nxt = GAP;
            GAP:   if (gap_cnt <= 4'd1) state_nxt = READ;
            READ: begin
                wrt       = 1'b1;
                state_nxt = WAIT2;
            end
            WAIT2: if (done_rise) state_nxt = STORE;
            STORE: begin
                store_en = 1'b1;
                if (pn_last) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SEND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask_q     <= '0;
            ch_q       <= '0;
            gap_cnt    <= '0;
            done_q     <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            done_q     <= spi_done;
            sweep_done <= finish | start_empty;
            if (start_go) begin
                mask_q <= ch_mask;
                ch_q   <= pn_nxt;
            end else if (store_en && !pn_last) begin
                ch_q <= pn_nxt;
            end
            if (state == WAIT1 && done_rise)
                gap_cnt <= 4'(GAP_CYC);
            else if (state == GAP)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_vld <= '0;
            for (int i = 0; i < NUM_CH; i++)
                res[i] <= '0;
        end else if (store_en) begin
            res[ch_q]     <= store_val;
            res_vld[ch_q] <= 1'b1;
        end
    end

endmodule
